reg_file_scoreboard: RTL

//   32 x 32-bit general register file with two read ports, one write port and
//   a per-register busy scoreboard. Sits directly upstream of the 32-way

---
 rtl/reg_file_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_file_scoreboard
//   General register file (2**AW entries of DW bits) with two combinational
//   read ports, one write port with same-cycle write-to-read bypass, and a
//   per-register busy scoreboard used by decode to detect read-after-write
//   hazards against instructions that have issued but not yet written back.
//
// Ports
//   Clk       clock, all state updates on the rising edge
//   Reset     synchronous active-high reset (clears registers and busy bits)
//   Ra1/Ra2   read addresses            Qa1/Qa2  read data (combinational)
//   We/Wa/Wd  writeback enable/address/data
//   Iss       issue valid; Iss_rd is the destination being marked busy
//   Flush     clears every busy bit (a same-cycle writeback still commits)
//   Hazard    a read port addresses a busy register not resolved this cycle
//   Busy_cnt  registered count of busy registers
// -----------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] Ra1,
    input  logic [AW-1:0] Ra2,
    output logic [DW-1:0] Qa1,
    output logic [DW-1:0] Qa2,
    input  logic          We,
    input  logic [AW-1:0] Wa,
    input  logic [DW-1:0] Wd,
    input  logic          Iss,
    input  logic [AW-1:0] Iss_rd,
    input  logic          Flush,
    output logic          Hazard,
    output logic [AW:0]   Busy_cnt
);

    localparam int NREG = 2**AW;

    // Register storage is a plain flop array: every entry must clear on reset
    // and both read ports are combinational, so no RAM macro fits here.
    logic [DW-1:0]   regs_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     busy_cnt_reg;
    logic [AW:0]     busy_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // Register 0 is hard-wired to zero and can never be busy.
                always_ff @(posedge Clk) begin
                    regs_reg[gi] <= '0;
                end
                assign busy_next[gi] = 1'b0;
            end else begin : g_entry
                always_ff @(posedge Clk) begin
                    if (Reset) begin
                        regs_reg[gi] <= '0;
                    end else if (We && (Wa == AW'(gi))) begin
                        regs_reg[gi] <= Wd;
                    end
                end
                // Flush beats everything; otherwise a new producer issuing to
                // the same register as this cycle's writeback keeps it busy.
                assign busy_next[gi] = Flush                          ? 1'b0 :
                                       (Iss && (Iss_rd == AW'(gi)))   ? 1'b1 :
                                       (We && (Wa == AW'(gi)))        ? 1'b0 :
                                                                        busy_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_next = busy_cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    // Read ports: a writeback landing this cycle is forwarded straight through.
    logic byp1;
    logic byp2;
    assign byp1 = We && (Wa == Ra1) && (Ra1 != '0);
    assign byp2 = We && (Wa == Ra2) && (Ra2 != '0);

    assign Qa1 = (Ra1 == '0) ? '0 : (byp1 ? Wd : regs_reg[Ra1]);
    assign Qa2 = (Ra2 == '0) ? '0 : (byp2 ? Wd : regs_reg[Ra2]);

    // The bypass also resolves the hazard for a writeback in the same cycle.
    logic haz1;
    logic haz2;
    assign haz1 = (Ra1 != '0) && busy_reg[Ra1] && !byp1;
    assign haz2 = (Ra2 != '0) && busy_reg[Ra2] && !byp2;

    assign Hazard   = haz1 || haz2;
    assign Busy_cnt = busy_cnt_reg;

endmodule
